// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of an asynchronous input in enabled
// sample ticks, and flags a stuck input when no edge is seen for MAX samples.
module pwm_capture #(
   parameter int CNT_BITWIDTH = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clk_en_i,
   input  logic                    PWM_pin_i,
   output logic [CNT_BITWIDTH-1:0] highCount_o,
   output logic [CNT_BITWIDTH-1:0] periodCount_o,
   output logic                    valid_o,
   output logic                    stuck_o,
   output logic                    level_o
);
   localparam logic [CNT_BITWIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_BITWIDTH-1:0] CNT_ONE = CNT_BITWIDTH'(1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t                  state;
   logic [1:0]              sync;
   logic                    s, p, rise, fall, edge_hit;
   logic [CNT_BITWIDTH-1:0] cnt, hreg;

   // Synchronizer and previous sample reset high: a pin already high at reset is not a rise.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync <= 2'b11;
      else       sync <= {sync[0], PWM_pin_i};
   end

   assign s    = sync[1];
   assign rise = s & ~p;
   assign fall = ~s & p;

   // Only the edge the current state waits for blocks the timeout; a fall in IDLE does not.
   always_comb begin
      edge_hit = 1'b0;
      case (state)
         IDLE:    edge_hit = rise;
         HIGH:    edge_hit = fall;
         LOW:     edge_hit = rise;
         default: edge_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= IDLE;
         cnt           <= '0;
         hreg          <= '0;
         p             <= 1'b1;
         highCount_o   <= '0;
         periodCount_o <= '0;
         valid_o       <= 1'b0;
         stuck_o       <= 1'b0;
         level_o       <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (clk_en_i) begin
            p <= s;
            if (!edge_hit && cnt == CNT_MAX) begin
               stuck_o <= 1'b1;
               level_o <= s;
               cnt     <= '0;
               state   <= IDLE;
            end else begin
               case (state)
                  IDLE: begin
                     if (rise) begin
                        cnt   <= CNT_ONE;
                        state <= HIGH;
                     end else begin
                        cnt <= cnt + CNT_ONE;
                     end
                  end
                  HIGH: begin
                     if (fall) begin
                        hreg  <= cnt;
                        state <= LOW;
                     end
                     cnt <= cnt + CNT_ONE;
                  end
                  LOW: begin
                     if (rise) begin
                        periodCount_o <= cnt;
                        highCount_o   <= hreg;
                        valid_o       <= 1'b1;
                        stuck_o       <= 1'b0;
                        cnt           <= CNT_ONE;
                        state         <= HIGH;
                     end else begin
                        cnt <= cnt + CNT_ONE;
                     end
                  end
                  default: begin
                     cnt   <= '0;
                     state <= IDLE;
                  end
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed scenarios plus randomized PWM, checked
// every cycle against a timestamp-based reference model of the measurement rules.
module tb_pwm_capture;
   localparam int W   = 5;
   localparam int MAX = 31;

   logic         clk = 1'b0;
   logic         rst, en, pin;
   logic [W-1:0] hc, pc;
   logic         valid, stuck, level;

   pwm_capture #(.CNT_BITWIDTH(W)) dut (
      .clk_i(clk), .rst_i(rst), .clk_en_i(en), .PWM_pin_i(pin),
      .highCount_o(hc), .periodCount_o(pc), .valid_o(valid), .stuck_o(stuck), .level_o(level)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // Reference model: sample indices and edge timestamps.
   // base marks the sample where "samples without a usable edge" started counting.
   logic         d1, d2, last_lvl;
   int           ph, smp, t_rise, t_fall, base;
   logic [W-1:0] m_hc, m_pc;
   logic         m_v, m_st, m_lv;

   task automatic model_init();
      d1 = 1'b1; d2 = 1'b1; last_lvl = 1'b1;
      ph = 0; smp = 0; t_rise = 0; t_fall = 0; base = 0;
      m_hc = '0; m_pc = '0; m_v = 1'b0; m_st = 1'b0; m_lv = 1'b0;
   endtask

   task automatic model_step();
      logic lvl, r, f;
      if (rst) begin
         model_init();
      end else begin
         lvl = d2; d2 = d1; d1 = pin;
         m_v = 1'b0;
         if (en) begin
            r = lvl & ~last_lvl;
            f = ~lvl & last_lvl;
            last_lvl = lvl;
            if (ph == 0 && r) begin
               ph = 1; t_rise = smp; base = smp;
            end else if (ph == 1 && f) begin
               ph = 2; t_fall = smp;
            end else if (ph == 2 && r) begin
               m_pc = W'(smp - t_rise);
               m_hc = W'(t_fall - t_rise);
               m_v = 1'b1; m_st = 1'b0;
               ph = 1; t_rise = smp; base = smp;
            end else if (smp - base == MAX) begin
               m_st = 1'b1; m_lv = lvl; ph = 0; base = smp + 1;
            end
            smp++;
         end
      end
   endtask

   // Drive inputs at the falling edge, let one rising edge act, return at the next falling edge.
   task automatic step(input logic pv, input logic ev);
      pin = pv; en = ev;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset(input logic lvl);
      pin = lvl; en = 1'b0; rst = 1'b1;
      model_init();
      step(lvl, 1'b0);
      step(lvl, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; pin = 1'b1;
      #2 rst = 1'b1;
      #1;
      nvec++;
      if ({valid, stuck, level, hc, pc} !== '0) begin
         nerr++;
         $display("FAIL reset_immediate got %b want 0", {valid, stuck, level, hc, pc});
      end
      @(negedge clk);
      model_init();
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      nvec++;
      if ({valid, stuck, level, hc, pc} !== '0) begin
         nerr++;
         $display("FAIL reset_held got %b want 0", {valid, stuck, level, hc, pc});
      end
   endtask

   task automatic test_steady();
      int nv, lastv;
      nv = 0; lastv = 0;
      do_reset(1'b1);
      for (int c = 0; c < 18 * 6; c++) begin
         step((c % 18) < 7, 1'b1);
         nvec++;
         if ({valid, stuck, level, hc, pc} !== {m_v, m_st, m_lv, m_hc, m_pc}) begin
            nerr++;
            $display("FAIL steady c=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     c, valid, stuck, level, hc, pc, m_v, m_st, m_lv, m_hc, m_pc);
         end
         if (valid) begin
            nvec++;
            if (hc !== 5'd7 || pc !== 5'd18 || (nv > 0 && c - lastv != 18)) begin
               nerr++;
               $display("FAIL steady_counts c=%0d got hc=%0d pc=%0d gap=%0d want 7/18/18", c, hc, pc, c - lastv);
            end
            nv++; lastv = c;
         end
      end
      nvec++;
      if (nv != 4) begin
         nerr++;
         $display("FAIL steady_valid_count got %0d want 4", nv);
      end
   endtask

   task automatic test_static_low();
      int nv;
      nv = 0;
      do_reset(1'b0);
      for (int c = 0; c < 80; c++) begin
         step(1'b0, 1'b1);
         nvec++;
         if ({valid, stuck, level, hc, pc} !== {m_v, m_st, m_lv, m_hc, m_pc}) begin
            nerr++;
            $display("FAIL static_low c=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     c, valid, stuck, level, hc, pc, m_v, m_st, m_lv, m_hc, m_pc);
         end
         if (valid) nv++;
      end
      nvec++;
      if (stuck !== 1'b1 || level !== 1'b0 || hc !== '0 || pc !== '0 || nv != 0) begin
         nerr++;
         $display("FAIL static_low_final got st=%b lv=%b hc=%0d pc=%0d nv=%0d want 1/0/0/0/0",
                  stuck, level, hc, pc, nv);
      end
   endtask

   task automatic test_static_high_recovery();
      int  nv;
      logic prev_st;
      nv = 0;
      do_reset(1'b1);
      for (int c = 0; c < 40; c++) begin
         step(1'b1, 1'b1);
         nvec++;
         if ({valid, stuck, level, hc, pc} !== {m_v, m_st, m_lv, m_hc, m_pc}) begin
            nerr++;
            $display("FAIL static_high c=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     c, valid, stuck, level, hc, pc, m_v, m_st, m_lv, m_hc, m_pc);
         end
      end
      nvec++;
      if (stuck !== 1'b1 || level !== 1'b1) begin
         nerr++;
         $display("FAIL static_high_flag got st=%b lv=%b want 1/1", stuck, level);
      end
      prev_st = stuck;
      for (int c = 0; c < 40; c++) begin
         step((c % 10) >= 7, 1'b1);
         nvec++;
         if ({valid, stuck, level, hc, pc} !== {m_v, m_st, m_lv, m_hc, m_pc}) begin
            nerr++;
            $display("FAIL recovery c=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     c, valid, stuck, level, hc, pc, m_v, m_st, m_lv, m_hc, m_pc);
         end
         if (valid && nv == 0) begin
            nvec++;
            if (stuck !== 1'b0 || prev_st !== 1'b1 || hc !== 5'd3 || pc !== 5'd10) begin
               nerr++;
               $display("FAIL recovery_first got st=%b prev_st=%b hc=%0d pc=%0d want 0/1/3/10",
                        stuck, prev_st, hc, pc);
            end
         end
         if (valid) nv++;
         prev_st = stuck;
      end
   endtask

   task automatic test_gating();
      int   nv;
      logic prev_v;
      nv = 0; prev_v = 1'b0;
      do_reset(1'b1);
      for (int c = 0; c < 36 * 5; c++) begin
         step((c % 36) < 14, c[0]);
         nvec++;
         if ({valid, stuck, level, hc, pc} !== {m_v, m_st, m_lv, m_hc, m_pc}) begin
            nerr++;
            $display("FAIL gating c=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     c, valid, stuck, level, hc, pc, m_v, m_st, m_lv, m_hc, m_pc);
         end
         if (valid) begin
            nv++;
            nvec++;
            if (hc !== 5'd7 || pc !== 5'd18 || prev_v !== 1'b0) begin
               nerr++;
               $display("FAIL gating_counts c=%0d got hc=%0d pc=%0d prev_v=%b want 7/18/0", c, hc, pc, prev_v);
            end
         end
         prev_v = valid;
      end
      nvec++;
      if (nv < 3) begin
         nerr++;
         $display("FAIL gating_valid_count got %0d want >=3", nv);
      end
   endtask

   task automatic test_boundary();
      int nv, late_v;
      nv = 0; late_v = 0;
      do_reset(1'b1);
      for (int c = 0; c < 31 * 5; c++) begin
         step((c % 31) == 0, 1'b1);
         nvec++;
         if ({valid, stuck, level, hc, pc} !== {m_v, m_st, m_lv, m_hc, m_pc}) begin
            nerr++;
            $display("FAIL bound31 c=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     c, valid, stuck, level, hc, pc, m_v, m_st, m_lv, m_hc, m_pc);
         end
         if (valid) begin
            nvec++;
            if (hc !== 5'd1 || pc !== 5'd31) begin
               nerr++;
               $display("FAIL bound31_counts got hc=%0d pc=%0d want 1/31", hc, pc);
            end
            nv++;
         end
         if (nv > 0 && stuck !== 1'b0) begin
            nvec++;
            nerr++;
            $display("FAIL bound31_stuck c=%0d got %b want 0", c, stuck);
         end
      end
      nvec++;
      if (nv < 3) begin
         nerr++;
         $display("FAIL bound31_valid_count got %0d want >=3", nv);
      end
      for (int c = 0; c < 32 * 3; c++) begin
         step((c % 32) == 0, 1'b1);
         nvec++;
         if ({valid, stuck, level, hc, pc} !== {m_v, m_st, m_lv, m_hc, m_pc}) begin
            nerr++;
            $display("FAIL bound32 c=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     c, valid, stuck, level, hc, pc, m_v, m_st, m_lv, m_hc, m_pc);
         end
         if (valid && c > 10) late_v++;
      end
      nvec++;
      if (stuck !== 1'b1 || hc !== 5'd1 || pc !== 5'd31 || late_v != 0) begin
         nerr++;
         $display("FAIL bound32_final got st=%b hc=%0d pc=%0d late_v=%0d want 1/1/31/0", stuck, hc, pc, late_v);
      end
   endtask

   task automatic test_reset_mid();
      int nv, c, first;
      nv = 0; c = 0; first = -1;
      do_reset(1'b1);
      while (nv < 2 && c < 200) begin
         step((c % 18) < 7, 1'b1);
         nvec++;
         if ({valid, stuck, level, hc, pc} !== {m_v, m_st, m_lv, m_hc, m_pc}) begin
            nerr++;
            $display("FAIL reset_mid_pre c=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     c, valid, stuck, level, hc, pc, m_v, m_st, m_lv, m_hc, m_pc);
         end
         if (valid) nv++;
         c++;
      end
      nvec++;
      if (nv < 2) begin
         nerr++;
         $display("FAIL reset_mid_wait got %0d valids want 2 within 200 cycles", nv);
      end
      step((c % 18) < 7, 1'b1); c++;
      step((c % 18) < 7, 1'b1); c++;
      rst = 1'b1;
      #1;
      nvec++;
      if ({valid, stuck, level, hc, pc} !== '0) begin
         nerr++;
         $display("FAIL reset_mid_clear got %b want 0", {valid, stuck, level, hc, pc});
      end
      model_init();
      step((c % 18) < 7, 1'b1); c++;
      rst = 1'b0;
      for (int k = 0; k < 80; k++) begin
         step((c % 18) < 7, 1'b1); c++;
         nvec++;
         if ({valid, stuck, level, hc, pc} !== {m_v, m_st, m_lv, m_hc, m_pc}) begin
            nerr++;
            $display("FAIL reset_mid_post k=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     k, valid, stuck, level, hc, pc, m_v, m_st, m_lv, m_hc, m_pc);
         end
         if (valid && first < 0) first = k;
      end
      nvec++;
      if (first < 18) begin
         nerr++;
         $display("FAIL reset_mid_first got first valid at %0d want >=18", first);
      end
   endtask

   // Random PWM and enable patterns; enable never skips two clocks in a row so lows of
   // two or more clocks are always sampled and high stretches stay below MAX samples.
   task automatic test_random();
      int   h, l;
      logic ev, last_ev;
      last_ev = 1'b1;
      for (int rnd = 0; rnd < 3; rnd++) begin
         do_reset(1'($urandom_range(0, 1)));
         for (int k = 0; k < 12; k++) begin
            h = $urandom_range(1, 25);
            l = $urandom_range(2, 70);
            for (int j = 0; j < h + l; j++) begin
               ev = (rnd == 0 || !last_ev) ? 1'b1 : 1'($urandom_range(0, 1));
               last_ev = ev;
               step(j < h, ev);
               nvec++;
               if ({valid, stuck, level, hc, pc} !== {m_v, m_st, m_lv, m_hc, m_pc}) begin
                  nerr++;
                  $display("FAIL random r=%0d k=%0d j=%0d got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                           rnd, k, j, valid, stuck, level, hc, pc, m_v, m_st, m_lv, m_hc, m_pc);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_steady();
      test_static_low();
      test_static_high_recovery();
      test_gating();
      test_boundary();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
